// File: rtl/murmur3_pkg.sv
// Shared constants and state encoding for the streaming MurmurHash3 x86_32 controller.
package murmur3_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned NBYTES_W = 3;

  localparam logic [WORD_W-1:0] C1        = 32'hCC9E2D51;
  localparam logic [WORD_W-1:0] C2        = 32'h1B873593;
  localparam logic [WORD_W-1:0] ROUND_ADD = 32'hE6546B64;
  localparam logic [WORD_W-1:0] FMIX_M1   = 32'h85EBCA6B;
  localparam logic [WORD_W-1:0] FMIX_M2   = 32'hC2B2AE35;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABSORB = 3'd1,
    FIN1   = 3'd2,
    FIN2   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/murmur3_stream_ctrl_if.sv
// Message-in / hash-out bus of the streaming MurmurHash3 controller.
interface murmur3_stream_ctrl_if;
  import murmur3_pkg::*;

  logic                start;
  logic [WORD_W-1:0]   seed;
  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_data;
  logic                in_last;
  logic [NBYTES_W-1:0] in_bytes;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_hash;
  logic                busy;

  // Source/consumer side.
  modport master (
    output start, seed, in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_hash, busy
  );

  // Hash controller side.
  modport slave (
    input  start, seed, in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_hash, busy
  );

endinterface

// File: rtl/murmur3_round.sv
// One MurmurHash3 absorb step: nbytes=0 passes h, 1..3 is the tail mix, 4 is a full body round.
module murmur3_round
  import murmur3_pkg::*;
(
  input  logic [WORD_W-1:0]   h,
  input  logic [WORD_W-1:0]   data,
  input  logic [NBYTES_W-1:0] nbytes,
  output logic [WORD_W-1:0]   h_next
);

  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] k_mul1;
  logic [WORD_W-1:0] k_rot;
  logic [WORD_W-1:0] k_mul2;
  logic [WORD_W-1:0] h_mix;
  logic [WORD_W-1:0] h_rot;

  // Key scramble shared by body and tail, then round-specific h update.
  always_comb begin
    mask = '1;
    case (nbytes)
      3'd1:    mask = 32'h0000_00FF;
      3'd2:    mask = 32'h0000_FFFF;
      3'd3:    mask = 32'h00FF_FFFF;
      default: mask = '1;
    endcase
    k_mul1 = (data & mask) * C1;
    k_rot  = {k_mul1[16:0], k_mul1[31:17]};
    k_mul2 = k_rot * C2;
    h_mix  = h ^ k_mul2;
    h_rot  = {h_mix[18:0], h_mix[31:19]};
    if (nbytes == 3'd0) begin
      h_next = h;
    end else if (nbytes < 3'd4) begin
      h_next = h_mix;
    end else begin
      h_next = (h_rot * 32'd5) + ROUND_ADD;
    end
  end

endmodule

// File: rtl/murmur3_stream_ctrl.sv
// Streaming MurmurHash3 x86_32 sequencer: seed, body/tail rounds, length xor, fmix32.
// Optional MURMUR3_STREAM_ABORT_EN adds an abort input that drops the message in flight.
module murmur3_stream_ctrl
  import murmur3_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  murmur3_stream_ctrl_if.slave bus
`ifdef MURMUR3_STREAM_ABORT_EN
  ,
  input  logic abort
`endif
);

  state_t              state, state_d;
  logic [WORD_W-1:0]   h, h_d;
  logic [LEN_W-1:0]    len, len_d;
  logic [WORD_W-1:0]   hash_q, hash_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                abort_hit;
  logic [NBYTES_W-1:0] round_nbytes;
  logic [WORD_W-1:0]   h_round;
  logic [WORD_W-1:0]   f1_x, f1_s, f1_h;
  logic [WORD_W-1:0]   f2_s, f2_m, f2_h;

`ifdef MURMUR3_STREAM_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Non-final words are always full body rounds.
  assign round_nbytes = bus.in_last ? bus.in_bytes : 3'd4;

  murmur3_round u_round (
    .h      (h),
    .data   (bus.in_data),
    .nbytes (round_nbytes),
    .h_next (h_round)
  );

  // fmix32, split across FIN1 and FIN2.
  assign f1_x = h ^ 32'(len);
  assign f1_s = f1_x ^ (f1_x >> 16);
  assign f1_h = f1_s * FMIX_M1;
  assign f2_s = h ^ (h >> 13);
  assign f2_m = f2_s * FMIX_M2;
  assign f2_h = f2_m ^ (f2_m >> 16);

  // Next-state and next-register values.
  always_comb begin
    state_d     = state;
    h_d         = h;
    len_d       = len;
    hash_d      = hash_q;
    out_valid_d = out_valid_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          h_d     = bus.seed;
          len_d   = '0;
          state_d = ABSORB;
        end
      end
      ABSORB: begin
        if (abort_hit) begin
          h_d     = '0;
          len_d   = '0;
          state_d = IDLE;
        end else if (bus.in_valid) begin
          h_d = h_round;
          if (bus.in_last) begin
            len_d   = len + LEN_W'(bus.in_bytes);
            state_d = FIN1;
          end else begin
            len_d = len + LEN_W'(3'd4);
          end
        end
      end
      FIN1: begin
        if (abort_hit) begin
          h_d     = '0;
          len_d   = '0;
          state_d = IDLE;
        end else begin
          h_d     = f1_h;
          state_d = FIN2;
        end
      end
      FIN2: begin
        if (abort_hit) begin
          h_d     = '0;
          len_d   = '0;
          state_d = IDLE;
        end else begin
          hash_d      = f2_h;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == ABSORB);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      h           <= '0;
      len         <= '0;
      hash_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      h           <= h_d;
      len         <= len_d;
      hash_q      <= hash_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_hash  = hash_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_murmur3_stream_ctrl.sv
// Directed bench for murmur3_stream_ctrl with a byte-level reference model and per-cycle compare.
module tb_murmur3_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  murmur3_stream_ctrl_if bus();
`ifdef MURMUR3_STREAM_ABORT_EN
  logic abort;
`endif

  murmur3_stream_ctrl #(.LEN_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MURMUR3_STREAM_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference MurmurHash3 x86_32 over a byte string.
  function automatic logic [31:0] rol(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] mm3_ref(input logic [7:0] msg[$], input logic [31:0] sd);
    int n;
    int nblk;
    logic [31:0] h;
    logic [31:0] k;
    n = msg.size();
    nblk = n / 4;
    h = sd;
    for (int i = 0; i < nblk; i++) begin
      k = {msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]};
      k = k * 32'hCC9E2D51;
      k = rol(k, 15);
      k = k * 32'h1B873593;
      h = h ^ k;
      h = rol(h, 13);
      h = h * 32'd5 + 32'hE6546B64;
    end
    k = 32'd0;
    for (int j = n - 1; j >= 4 * nblk; j--) k = (k << 8) | 32'(msg[j]);
    if ((n % 4) != 0) begin
      k = k * 32'hCC9E2D51;
      k = rol(k, 15);
      k = k * 32'h1B873593;
      h = h ^ k;
    end
    h = h ^ 32'(n);
    h = h ^ (h >> 16);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    h = h * 32'hC2B2AE35;
    h = h ^ (h >> 16);
    return h;
  endfunction

  // Transaction-level model: idle / open message / finishing / result held.
  logic [7:0]  m_bytes[$];
  logic [31:0] m_seed = 32'd0;
  logic [31:0] m_hash = 32'd0;
  logic        m_idle = 1'b1;
  logic        m_open = 1'b0;
  logic        m_valid = 1'b0;
  int          m_cnt = 0;
  logic [2:0]  tb_nb;
  logic        abort_now;

  assign tb_nb = bus.in_last ? bus.in_bytes : 3'd4;
`ifdef MURMUR3_STREAM_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_open  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_bytes.delete();
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid <= 1'b0;
        m_idle  <= 1'b1;
      end
    end else if (m_cnt > 0) begin
      if (abort_now) begin
        m_cnt  <= 0;
        m_idle <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_valid <= 1'b1;
          m_hash  <= mm3_ref(m_bytes, m_seed);
        end
      end
    end else if (m_open) begin
      if (abort_now) begin
        m_open <= 1'b0;
        m_idle <= 1'b1;
      end else if (bus.in_valid) begin
        if (tb_nb >= 3'd1) m_bytes.push_back(bus.in_data[7:0]);
        if (tb_nb >= 3'd2) m_bytes.push_back(bus.in_data[15:8]);
        if (tb_nb >= 3'd3) m_bytes.push_back(bus.in_data[23:16]);
        if (tb_nb >= 3'd4) m_bytes.push_back(bus.in_data[31:24]);
        if (bus.in_last) begin
          m_open <= 1'b0;
          m_cnt  <= 2;
        end
      end
    end else if (m_idle && bus.start) begin
      m_idle <= 1'b0;
      m_open <= 1'b1;
      m_seed <= bus.seed;
      m_bytes.delete();
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_in_ready", bus.in_ready, 1'b0);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk("rst_out_hash", bus.out_hash, 32'd0);
    end else begin
      chk1("cyc_in_ready", bus.in_ready, m_open);
      chk1("cyc_busy", bus.busy, !m_idle);
      chk1("cyc_out_valid", bus.out_valid, m_valid);
      if (m_valid) chk("cyc_out_hash", bus.out_hash, m_hash);
    end
  end

  // Driver helpers; all start and return at posedge + 1.
  task automatic start_msg(input logic [31:0] sd);
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk1("wait_idle", bus.busy, 1'b0);
    bus.start = 1'b1;
    bus.seed  = sd;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic last, input logic [2:0] nb,
                           input bit gapped);
    int n;
    if (gapped) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = nb;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk1("accept_wait", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Waits for the result, checks it (and optionally the 2-edge latency), then consumes it.
  task automatic collect(input string name, input logic [31:0] exp, input bit lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (lat) chk({name, "_latency"}, 32'(n), 32'd2);
    chk1({name, "_valid"}, bus.out_valid, 1'b1);
    chk(name, bus.out_hash, exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic one_word(input string name, input logic [31:0] sd, input logic [31:0] d,
                          input logic [2:0] nb, input logic [31:0] exp, input bit lat);
    start_msg(sd);
    push_word(d, 1'b1, nb, 1'b0);
    collect(name, exp, lat);
  endtask

  logic [7:0] q[$];
  logic [7:0] hello[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                            8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.seed      = 32'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = 3'd0;
    bus.out_ready = 1'b0;
`ifdef MURMUR3_STREAM_ABORT_EN
    abort = 1'b0;
`endif

    // Pin the reference model on published vectors.
    q.delete();
    chk("model_empty_s1", mm3_ref(q, 32'h00000001), 32'h514E28B7);
    q.push_back(8'h61);
    chk("model_a", mm3_ref(q, 32'h9747B28C), 32'h7FA09EA6);
    q.push_back(8'h61); q.push_back(8'h61); q.push_back(8'h61);
    chk("model_aaaa", mm3_ref(q, 32'h9747B28C), 32'h5A97808A);
    q.delete();
    for (int i = 0; i < 13; i++) q.push_back(hello[i]);
    chk("model_hello", mm3_ref(q, 32'h9747B28C), 32'h24884CBA);

    #1;
    chk1("reset_in_ready", bus.in_ready, 1'b0);
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_hash", bus.out_hash, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    one_word("empty_s0", 32'h00000000, 32'd0, 3'd0, 32'h00000000, 1'b0);
    one_word("empty_s1", 32'h00000001, 32'd0, 3'd0, 32'h514E28B7, 1'b0);
    one_word("empty_sff", 32'hFFFFFFFF, 32'd0, 3'd0, 32'h81F16F39, 1'b0);
    one_word("zero_word", 32'h00000000, 32'd0, 3'd4, 32'h2362F9DE, 1'b1);
    one_word("a", 32'h9747B28C, 32'h00000061, 3'd1, 32'h7FA09EA6, 1'b1);
    one_word("aaaa", 32'h9747B28C, 32'h61616161, 3'd4, 32'h5A97808A, 1'b1);

    // Gapped multi-word message.
    start_msg(32'h9747B28C);
    push_word(32'h6C6C6548, 1'b0, 3'd4, 1'b1);
    push_word(32'h77202C6F, 1'b0, 3'd4, 1'b1);
    push_word(32'h646C726F, 1'b0, 3'd4, 1'b1);
    push_word(32'h00000021, 1'b1, 3'd1, 1'b1);
    collect("hello", 32'h24884CBA, 1'b1);

    // Backpressure: result held, start ignored in DONE and on the release cycle.
    start_msg(32'h9747B28C);
    push_word(32'h61616161, 1'b1, 3'd4, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3);
      bus.seed  = 32'h12345678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk1("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_out_hash", bus.out_hash, 32'h5A97808A);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk1("bp_release_valid", bus.out_valid, 1'b0);
    chk1("bp_release_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    chk1("bp_start_ignored", bus.busy, 1'b0);
    one_word("after_bp", 32'h9747B28C, 32'h00000061, 3'd1, 32'h7FA09EA6, 1'b1);

    // Reset mid-message.
    start_msg(32'h9747B28C);
    push_word(32'h6C6C6548, 1'b0, 3'd4, 1'b0);
    push_word(32'h77202C6F, 1'b0, 3'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("midrst_in_ready", bus.in_ready, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_hash", bus.out_hash, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    one_word("after_rst", 32'h9747B28C, 32'h61616161, 3'd4, 32'h5A97808A, 1'b1);

`ifdef MURMUR3_STREAM_ABORT_EN
    // Abort mid-message, colliding with a word handshake.
    start_msg(32'h9747B28C);
    push_word(32'h6C6C6548, 1'b0, 3'd4, 1'b0);
    push_word(32'h77202C6F, 1'b0, 3'd4, 1'b0);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h646C726F;
    @(posedge clk); #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_in_ready", bus.in_ready, 1'b0);
    chk1("abort_out_valid", bus.out_valid, 1'b0);
    one_word("after_abort", 32'h9747B28C, 32'h61616161, 3'd4, 32'h5A97808A, 1'b1);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
